// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front-end blocks.
// Pixels and weights are signed Q2.14 words.
package conv_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 14;

  typedef logic signed [DATA_W-1:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_EMIT_K = 3'd2,
    ST_IMAGE  = 3'd3,
    ST_DRAIN  = 3'd4
  } feeder_state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// K-1 row history for the window feeder: one write and one K-1 deep column read at x.
// Physical rows rotate on each row wrap; read index 0 is always the oldest row.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  localparam int ROWS = KERNEL_SIZE - 1,
  localparam int XW   = $clog2(IMG_WIDTH),
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  we,
  input  logic [XW-1:0]                         x,
  input  logic signed [DATA_WIDTH-1:0]          din,
  output logic signed [ROWS-1:0][DATA_WIDTH-1:0] rd
);

  logic signed [DATA_WIDTH-1:0] mem [ROWS][IMG_WIDTH];
  logic [RW-1:0] top;
  logic          wrap;

  assign wrap = we && (x == XW'(IMG_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top <= '0;
    end else if (clr) begin
      top <= '0;
    end else if (wrap) begin
      top <= RW'(wrap_inc(int'(top), ROWS));
    end
  end

  // The oldest row is overwritten by the incoming pixel after it has been read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[top][x] <= din;
    end
  end

  always_comb begin
    int r;
    r = 0;
    for (int j = 0; j < ROWS; j++) begin
      r = int'(top) + j;
      if (r >= ROWS) r = r - ROWS;
      rd[j] = mem[RW'(r)][x];
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Streaming front-end for the KxK convolution unit: loads a kernel, then turns a
// raster-order frame into K-element column vectors plus shift/latch/result strobes.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic signed [DATA_WIDTH-1:0]                 s_data,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  output logic signed [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] col_out,
  output logic                                         kernel_load,
  output logic                                         valid_in,
  output logic                                         valid_out,
  output logic                                         result_valid,
  output logic                                         busy,
  output logic                                         frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int KW = $clog2(KK);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD_K = ST_LOAD_K;
  localparam logic [2:0] S_EMIT_K = ST_EMIT_K;
  localparam logic [2:0] S_IMAGE  = ST_IMAGE;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;

  logic [2:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [KW-1:0] kidx;
  logic          drain_cnt;

  logic signed [DATA_WIDTH-1:0]            wk [KK];
  logic signed [K-2:0][DATA_WIDTH-1:0]     lb_rd;
  logic signed [K-1:0][DATA_WIDTH-1:0]     col_p1;
  logic                                    kl_p1, vld_p1, win_p1, vld_p2, vld_p3, done_p1;

  logic accept, x_last, y_last, k_last, c_last, win_p0, lb_we, lb_clr;

  assign s_ready = (state == S_LOAD_K) || (state == S_IMAGE);
  assign busy    = (state != S_IDLE);
  assign accept  = s_valid && s_ready;
  assign x_last  = (x == XW'(IMG_WIDTH - 1));
  assign y_last  = (y == YW'(IMG_HEIGHT - 1));
  assign k_last  = (kidx == KW'(KK - 1));
  assign c_last  = (kidx == KW'(K - 1));
  assign win_p0  = (y >= YW'(K - 1)) && (x >= XW'(K - 1));
  assign lb_we   = (state == S_IMAGE) && accept;
  assign lb_clr  = (state == S_IDLE) && start;

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_SIZE(KERNEL_SIZE),
    .IMG_WIDTH  (IMG_WIDTH)
  ) u_line_buffer (
    .clk(clk),
    .rst(rst),
    .clr(lb_clr),
    .we (lb_we),
    .x  (x),
    .din(s_data),
    .rd (lb_rd)
  );

  // Kernel store: loads as a shift chain, then each row rotates left once per
  // emitted column so position r*K always holds w[r][c].
  always_ff @(posedge clk) begin
    if (state == S_LOAD_K && accept) begin
      for (int i = 0; i < KK - 1; i++) wk[i] <= wk[i + 1];
      wk[KK-1] <= s_data;
    end else if (state == S_EMIT_K) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          wk[r*K + c] <= wk[r*K + ((c == K - 1) ? 0 : c + 1)];
    end
  end

  // p0 -> p1: column/strobe register; p1 -> p2: latch strobe; p2 -> p3: result strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      kidx      <= '0;
      drain_cnt <= 1'b0;
      col_p1    <= '0;
      kl_p1     <= 1'b0;
      vld_p1    <= 1'b0;
      win_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      kl_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      vld_p2  <= vld_p1 && win_p1;
      vld_p3  <= vld_p2;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD_K;
            x         <= '0;
            y         <= '0;
            kidx      <= '0;
            drain_cnt <= 1'b0;
          end
        end
        S_LOAD_K: begin
          if (accept) begin
            if (k_last) begin
              kidx  <= '0;
              state <= S_EMIT_K;
            end else begin
              kidx <= kidx + 1'b1;
            end
          end
        end
        S_EMIT_K: begin
          for (int j = 0; j < K; j++) col_p1[j] <= wk[j*K];
          kl_p1  <= 1'b1;
          vld_p1 <= 1'b1;
          win_p1 <= 1'b0;
          if (c_last) begin
            kidx  <= '0;
            state <= S_IMAGE;
          end else begin
            kidx <= kidx + 1'b1;
          end
        end
        S_IMAGE: begin
          if (accept) begin
            for (int j = 0; j < K - 1; j++) col_p1[j] <= lb_rd[j];
            col_p1[K-1] <= s_data;
            vld_p1      <= 1'b1;
            win_p1      <= win_p0;
            if (x_last) begin
              x <= '0;
              y <= y_last ? '0 : y + 1'b1;
              if (y_last) state <= S_DRAIN;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            done_p1   <= 1'b1;
            state     <= S_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign col_out      = col_p1;
  assign kernel_load  = kl_p1;
  assign valid_in     = vld_p1;
  assign valid_out    = vld_p2;
  assign result_valid = vld_p3;
  assign frame_done   = done_p1;

endmodule
